// File: rtl/demux4_dispatcher_pkg.sv
// Shared definitions for the 1-to-4 dispatcher: FSM state encoding, mode
// constants, channel count and the round-robin pointer helper.
package demux4_dispatcher_pkg;

   localparam int NCH = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   function automatic logic [1:0] rr_advance(input logic [1:0] ptr);
      return ptr + 2'd1;
   endfunction

endpackage

// File: rtl/demux4_dispatcher_valid_demux4.sv
// One-hot valid decoder: raises exactly one sink valid while a word is held.
module valid_demux4
   import demux4_dispatcher_pkg::*;
(
   input  logic           hold,
   input  logic [1:0]     sel,
   output logic [NCH-1:0] out_valid
);

   always_comb begin
      out_valid = '0;
      if (hold) out_valid[sel] = 1'b1;
   end

endmodule

// File: rtl/demux4_dispatcher.sv
// 1-to-4 dispatcher: captures one word per handshake and presents it to an
// addressed or round-robin sink. Optional drop-on-timeout via DEMUX_TIMEOUT_EN.
module demux4_dispatcher
   import demux4_dispatcher_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_dest,
   input  logic             mode,
   output logic             in_ready,
   output logic [NCH-1:0]   out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic [NCH-1:0]   out_ready,
   output logic [1:0]       sel,
   output logic             busy,
   output logic [7:0]       drop_cnt
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("demux4_dispatcher: TIMEOUT must be in 1..255");
   end

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [1:0]       sel_q;
   logic [1:0]       rr_ptr;
   logic [1:0]       rr_ptr_nxt;
   logic             rr_word;
   logic             hold;
   logic             xfer;
   logic             drop;
   logic             leave;
   logic             capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid) state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (drop)      state_nxt = ST_IDLE;
            else if (xfer) state_nxt = in_valid ? ST_HOLD : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A drop cycle needs no special case here: the selected ready is low then.
   always_comb begin
      hold     = (state == ST_HOLD);
      busy     = hold;
      in_ready = hold ? out_ready[sel_q] : 1'b1;
   end

   // A back-to-back round-robin capture must see the pointer already advanced
   // by the word leaving on the same edge.
   always_comb begin
      xfer       = hold & out_ready[sel_q];
      leave      = xfer | drop;
      capture    = in_valid & in_ready;
      rr_ptr_nxt = (leave && rr_word) ? rr_advance(rr_ptr) : rr_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         sel_q   <= 2'd0;
         rr_ptr  <= 2'd0;
         rr_word <= 1'b0;
      end else begin
         rr_ptr <= rr_ptr_nxt;
         if (capture) begin
            data_q  <= in_data;
            sel_q   <= (mode == MODE_ADDR) ? in_dest : rr_ptr_nxt;
            rr_word <= (mode == MODE_RR);
         end
      end
   end

`ifdef DEMUX_TIMEOUT_EN
   logic [7:0] wait_cnt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb drop = hold & ~xfer & (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
         drop_cnt <= 8'd0;
      end else begin
         if (capture)           wait_cnt <= 8'd0;
         else if (hold && !xfer) wait_cnt <= wait_cnt + 8'd1;
         if (drop) drop_cnt <= sat_inc(drop_cnt);
      end
   end
`else
   always_comb drop = 1'b0;
   assign drop_cnt = 8'd0;
`endif

   valid_demux4 u_valid_demux4 (
      .hold      (hold),
      .sel       (sel_q),
      .out_valid (out_valid)
   );

   assign out_data = data_q;
   assign sel      = sel_q;

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Self-checking bench for demux4_dispatcher: directed scenarios plus a random
// phase, all checked against a word-level behavioural model.
module tb_demux4_dispatcher;

   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic [1:0] in_dest = 2'd0;
   logic       mode = 1'b0;
   logic       in_ready;
   logic [3:0] out_valid;
   logic [7:0] out_data;
   logic [3:0] out_ready = 4'd0;
   logic [1:0] sel;
   logic       busy;
   logic [7:0] drop_cnt;

   int tests = 0;
   int fails = 0;

   // behavioural model: is a word held, which word, where, and who chose it
   logic       m_held;
   logic [7:0] m_word;
   logic [1:0] m_dest;
   logic       m_rr_word;
   int         m_rr;
   int         m_age;
   int         m_drops;

   demux4_dispatcher #(.WIDTH(8), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .mode      (mode),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_held = 1'b0; m_word = 8'd0; m_dest = 2'd0; m_rr_word = 1'b0;
      m_rr = 0; m_age = 0; m_drops = 0;
   endtask

   // apply inputs mid-cycle and compare all outputs with the model
   task automatic step(input logic v, input logic [7:0] d, input logic [1:0] dest,
                       input logic md, input logic [3:0] rdy);
      logic [3:0] ev;
      @(negedge clk);
      in_valid = v; in_data = d; in_dest = dest; mode = md; out_ready = rdy;
      #1;
      ev = m_held ? (4'd1 << m_dest) : 4'd0;
      check("out_valid", 32'(out_valid), 32'(ev));
      check("in_ready", 32'(in_ready), 32'(!m_held || rdy[m_dest]));
      check("busy", 32'(busy), 32'(m_held));
`ifdef DEMUX_TIMEOUT_EN
      check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`else
      check("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      if (m_held) begin
         check("out_data", 32'(out_data), 32'(m_word));
         check("sel", 32'(sel), 32'(m_dest));
      end
   endtask

   // advance the model by one clock using the inputs now applied
   task automatic tick();
      logic acc;
      logic gone;
      acc  = in_valid && (!m_held || out_ready[m_dest]);
      gone = 1'b0;
      if (m_held) begin
         if (out_ready[m_dest]) gone = 1'b1;
`ifdef DEMUX_TIMEOUT_EN
         else if (m_age + 1 >= TMO) begin
            gone = 1'b1;
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
         end
`endif
         else m_age++;
         if (gone) begin
            m_held = 1'b0;
            if (m_rr_word) m_rr = (m_rr + 1) % 4;
         end
      end
      if (acc) begin
         m_held = 1'b1; m_word = in_data;
         m_dest = mode ? 2'(m_rr) : in_dest;
         m_rr_word = mode; m_age = 0;
      end
      @(posedge clk);
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] dest,
                      input logic md, input logic [3:0] rdy);
      step(v, d, dest, md, rdy);
      tick();
   endtask

   initial begin
      logic [1:0] dests[4];
      logic [3:0] seq[4];
      int n;
      dests = '{2'd3, 2'd0, 2'd2, 2'd1};
      seq   = '{4'h8, 4'h1, 4'h4, 4'h2};
      m_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // addressed, back-to-back
      for (int i = 0; i < 5; i++) begin
         step(i < 4, 8'hA1 + 8'(i), dests[i % 4], 1'b0, 4'hF);
         if (i > 0) begin
            check("addr_valid", 32'(out_valid), 32'(seq[i-1]));
            check("addr_data", 32'(out_data), 32'(8'hA1 + 8'(i - 1)));
         end
         tick();
      end

      // round-robin, six words then a seventh to expose the pointer
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 8'hB0 + 8'(i), 2'd3, 1'b1, 4'hF);
         if (i > 0) check("rr_sel", 32'(sel), 32'((i - 1) % 4));
         tick();
      end
      step(1'b0, 8'h00, 2'd0, 1'b1, 4'hF);
      check("rr_ptr_end", 32'(sel), 32'd2);
      tick();

      // backpressure on channel 2
      cyc(1'b1, 8'hD3, 2'd2, 1'b0, 4'b1011);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 2'd0, 1'b0, 4'b1011);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_valid", 32'(out_valid), 32'h4);
         tick();
      end
      step(1'b0, 8'h00, 2'd0, 1'b0, 4'b0100);
      check("bp_release", 32'(in_ready), 32'd1);
      tick();
      step(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
      check("bp_idle", 32'(busy), 32'd0);
      tick();

`ifdef DEMUX_TIMEOUT_EN
      for (int rep = 0; rep < 300; rep++) begin
         cyc(1'b1, 8'(rep), 2'd1, 1'b0, 4'h0);
         n = 0;
         for (int k = 0; k < 100; k++) begin
            step(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
            if (!busy) break;
            n++;
            tick();
         end
         tick();
         if (rep == 0) begin
            check("to_hold_cycles", 32'(n), 32'(TMO));
            check("to_drop_one", 32'(drop_cnt), 32'd1);
         end
      end
      step(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
      check("to_drop_sat", 32'(drop_cnt), 32'd255);
      tick();
`else
      cyc(1'b1, 8'h5A, 2'd1, 1'b0, 4'h0);
      for (int k = 0; k < 1000; k++) cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
      step(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
      check("nt_still_held", 32'(out_valid), 32'h2);
      check("nt_data", 32'(out_data), 32'h5A);
      tick();
      cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'h2);
`endif

      // asynchronous reset while holding
      cyc(1'b1, 8'hE1, 2'd0, 1'b1, 4'h0);
      cyc(1'b0, 8'h00, 2'd0, 1'b1, 4'h0);
      #2;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_sel", 32'(sel), 32'd0);
      check("ar_drop_cnt", 32'(drop_cnt), 32'd0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 8'hE2, 2'd3, 1'b1, 4'hF);
      step(1'b0, 8'h00, 2'd0, 1'b1, 4'hF);
      check("ar_first_rr", 32'(out_valid), 32'h1);
      tick();

      // mode switch while held
      cyc(1'b1, 8'hF6, 2'd0, 1'b1, 4'h0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 8'h00, 2'd3, 1'b0, 4'h0);
         check("ms_sel_kept", 32'(sel), 32'd1);
         tick();
      end
      cyc(1'b0, 8'h00, 2'd3, 1'b0, 4'b0010);
      cyc(1'b1, 8'hF7, 2'd0, 1'b1, 4'hF);
      step(1'b0, 8'h00, 2'd0, 1'b1, 4'hF);
      check("ms_rr_after", 32'(sel), 32'd2);
      tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
             1'($urandom_range(0, 1)), 4'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
